fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage sitting between the PC register and decode.
//  Issues one instruction-memory request per PC, drives PCWrite back to the PC register,
//  absorbs variable imem latency and decode stalls, and drops wrong-path fetches on redirect.
//  Its outputs are the IF/ID pipeline register: instr/PC/PC+4 plus a valid bit.
// PARAMETERS
//  WIDTH  32            address/data width
//  NOP    32'h00000013  instruction placed in instr_d_o on reset/flush (addi x0,x0,0)
// PORTS
//  clk            in   1      clock, rising edge
//  rst            in   1      reset, asynchronous, active-high
//  pc_i           in   WIDTH  current PC from PC register
//  pc_plus4_i     in   WIDTH  PC+4 from PC register
//  pc_write_o     out  1      PCWrite enable to PC register
//  flush_i        in   1      redirect (PCSrc != 00 resolved downstream); kill wrong-path work
//  imem_req_o     out  1      fetch request valid
//  imem_addr_o    out  WIDTH  fetch address (= pc_i)
//  imem_gnt_i     in   1      request accepted this cycle
//  imem_rvalid_i  in   1      response data valid (>=1 cycle after gnt)
//  imem_rdata_i   in   WIDTH  fetched instruction
//  stall_d_i      in   1      decode cannot accept new instruction
//  valid_d_o      out  1      IF/ID holds a valid instruction
//  instr_d_o      out  WIDTH  IF/ID instruction
//  pc_d_o         out  WIDTH  IF/ID PC
//  pc_plus4_d_o   out  WIDTH  IF/ID PC+4
// BEHAVIOUR
//  Reset: state=REQ, valid_d_o=0, instr_d_o=NOP, pc_d_o=0, pc_plus4_d_o=0, skid empty;
//    imem_req_o=0 and pc_write_o=0 while rst high.
//  Consume = valid_d_o & ~stall_d_i. Free = ~valid_d_o | consume.
//  Max one outstanding imem request. One-entry skid buffer {instr,pc,pc4,full}.
//  FSM:
//   REQ:   imem_req_o = ~skid_full & ~flush_i; imem_addr_o = pc_i.
//          On req&gnt: latch req_pc=pc_i, req_pc4=pc_plus4_i; pc_write_o=1; -> WAIT.
//   WAIT:  imem_req_o=0. On rvalid: if Free, load IF/ID (valid=1), else load skid (full=1); -> REQ.
//   DRAIN: imem_req_o=0. On rvalid: discard data; -> REQ.
//  Flush (highest priority, any state):
//   - pc_write_o=1 that cycle (PC loads redirect target).
//   - IF/ID: valid<=0, instr<=NOP. Skid full<=0.
//   - WAIT, or REQ with gnt in the same cycle as flush: -> DRAIN.
//   - WAIT with rvalid in the same cycle: response dropped; -> REQ.
//  IF/ID update without flush, priority: skid (if full & Free) > in-cycle response > clear valid on consume.
//  With a full skid and a response both present, the response goes to IF/ID only if the skid
//  drained that cycle; a full skid blocks new requests, so this case does not arise.
//  Stall: IF/ID held stable while valid_d_o & stall_d_i.
//  pc_write_o = flush_i | (imem_req_o & imem_gnt_i); otherwise 0.
//  Latency: gnt in cycle N, rvalid in cycle N+k -> valid_d_o high from N+k+1 when decode free.
//  Zero-wait back-to-back throughput is one instruction every 2 cycles (REQ/WAIT alternation).
//  No address arithmetic here: all PC values pass through unmodified.
// TESTING
//  1 Reset: hold rst 3 cycles -> valid_d_o=0, instr_d_o=0x13, imem_req_o=0, pc_write_o=0.
//  2 Straight line: gnt immediate, rvalid 1 cycle later; pc 0,4,8 -> IF/ID shows (0,4),(4,8),
//    (8,12) with the correct rdata; pc_write_o pulses once per gnt.
//  3 Stall + skid: stall_d_i=1 with IF/ID valid(pc=0x4) and response for 0x8 arriving -> skid
//    full, imem_req_o=0; release stall -> IF/ID=0x8 next cycle, then requests resume.
//  4 Flush in WAIT: flush at pc=0x10 outstanding, rvalid 2 cycles later -> valid_d_o=0,
//    pc_write_o=1 on flush cycle, data dropped, next request addr = redirect target (0x100).
//  5 Flush with simultaneous gnt -> DRAIN, the following rvalid discarded, never visible on IF/ID.
//  6 Async reset mid-WAIT: rst pulsed between clock edges -> outputs reset immediately;
//    a late rvalid after reset release is ignored (state REQ).

Source files
------------

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
// One request in flight at a time; rvalid follows gnt by at least one cycle.
interface fetch_stage_if #(
  parameter int unsigned WIDTH = 32
);
  logic             req;
  logic [WIDTH-1:0] addr;
  logic             gnt;
  logic             rvalid;
  logic [WIDTH-1:0] rdata;

  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: one outstanding imem request per PC, one-entry skid
// buffer for decode stalls, and wrong-path response dropping on redirect.
module fetch_stage #(
  parameter int unsigned      WIDTH = 32,
  parameter logic [WIDTH-1:0] NOP   = WIDTH'(32'h0000_0013)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pc_i,
  input  logic [WIDTH-1:0] pc_plus4_i,
  output logic             pc_write_o,
  input  logic             flush_i,
  fetch_stage_if.master    imem,
  input  logic             stall_d_i,
  output logic             valid_d_o,
  output logic [WIDTH-1:0] instr_d_o,
  output logic [WIDTH-1:0] pc_d_o,
  output logic [WIDTH-1:0] pc_plus4_d_o
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t           state, state_next;
  logic             req_c;
  logic             grant_c;
  logic             free_c;
  logic             rsp_take_c;

  logic [WIDTH-1:0] req_pc, req_pc4;
  logic             skid_full;
  logic [WIDTH-1:0] skid_instr, skid_pc, skid_pc4;

  assign imem.req    = req_c;
  assign imem.addr   = pc_i;
  assign grant_c     = req_c & imem.gnt;
  assign pc_write_o  = ~rst & (flush_i | grant_c);
  assign free_c      = ~valid_d_o | ~stall_d_i;
  assign rsp_take_c  = (state == S_WAIT) & imem.rvalid & ~flush_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_REQ;
    else     state <= state_next;
  end

  // Next state and request strobe; flush overrides every other transition.
  always_comb begin
    state_next = state;
    req_c      = 1'b0;
    if (state == S_REQ) req_c = ~skid_full & ~flush_i & ~rst;
    case (state)
      S_REQ: begin
        if (flush_i) begin
          if (imem.gnt) state_next = S_DRAIN;
        end else if (grant_c) begin
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (flush_i)          state_next = imem.rvalid ? S_REQ : S_DRAIN;
        else if (imem.rvalid) state_next = S_REQ;
      end
      S_DRAIN: begin
        if (imem.rvalid) state_next = S_REQ;
      end
      default: state_next = S_REQ;
    endcase
  end

  // PC pair of the request in flight, tagged onto its response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_pc  <= '0;
      req_pc4 <= '0;
    end else if (grant_c) begin
      req_pc  <= pc_i;
      req_pc4 <= pc_plus4_i;
    end
  end

  // IF/ID register and skid buffer: skid drains first, then a fresh response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_d_o    <= 1'b0;
      instr_d_o    <= NOP;
      pc_d_o       <= '0;
      pc_plus4_d_o <= '0;
      skid_full    <= 1'b0;
      skid_instr   <= NOP;
      skid_pc      <= '0;
      skid_pc4     <= '0;
    end else if (flush_i) begin
      valid_d_o <= 1'b0;
      instr_d_o <= NOP;
      skid_full <= 1'b0;
    end else if (skid_full && free_c) begin
      valid_d_o    <= 1'b1;
      instr_d_o    <= skid_instr;
      pc_d_o       <= skid_pc;
      pc_plus4_d_o <= skid_pc4;
      skid_full    <= 1'b0;
    end else if (rsp_take_c) begin
      if (free_c) begin
        valid_d_o    <= 1'b1;
        instr_d_o    <= imem.rdata;
        pc_d_o       <= req_pc;
        pc_plus4_d_o <= req_pc4;
      end else begin
        skid_full  <= 1'b1;
        skid_instr <= imem.rdata;
        skid_pc    <= req_pc;
        skid_pc4   <= req_pc4;
      end
    end else if (valid_d_o && !stall_d_i) begin
      valid_d_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, straight-line fetch, stall/skid,
// flush in WAIT, flush with grant, and asynchronous reset mid-request.
module tb_fetch_stage;

  localparam int unsigned WIDTH = 32;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] pc, pc4;
  logic             pc_write;
  logic             flush;
  logic             stall;
  logic             valid_d;
  logic [WIDTH-1:0] instr_d, pc_d, pc4_d;

  int checks   = 0;
  int failures = 0;

  fetch_stage_if #(.WIDTH(WIDTH)) bus ();

  fetch_stage #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .pc_i         (pc),
    .pc_plus4_i   (pc4),
    .pc_write_o   (pc_write),
    .flush_i      (flush),
    .imem         (bus),
    .stall_d_i    (stall),
    .valid_d_o    (valid_d),
    .instr_d_o    (instr_d),
    .pc_d_o       (pc_d),
    .pc_plus4_d_o (pc4_d)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pc(input logic [31:0] p);
    pc  = p;
    pc4 = p + 32'd4;
  endtask

  // Present a PC with gnt in the REQ cycle and expect it to be issued.
  task automatic req_grant(input logic [31:0] p);
    set_pc(p);
    bus.gnt = 1'b1;
    #1;
    chk("req_issue",  32'(bus.req),  32'd1);
    chk("req_addr",   bus.addr,      p);
    chk("req_pcwr",   32'(pc_write), 32'd1);
    tick();
    bus.gnt = 1'b0;
  endtask

  // Return data in the WAIT cycle.
  task automatic respond(input logic [31:0] d);
    bus.rvalid = 1'b1;
    bus.rdata  = d;
    #1;
    chk("wait_noreq", 32'(bus.req),  32'd0);
    chk("wait_pcwr",  32'(pc_write), 32'd0);
    tick();
    bus.rvalid = 1'b0;
  endtask

  task automatic chk_ifid(input string tag, input logic v, input logic [31:0] p,
                          input logic [31:0] i);
    chk({tag, "_valid"}, 32'(valid_d), 32'(v));
    chk({tag, "_instr"}, instr_d, i);
    if (v) begin
      chk({tag, "_pc"},  pc_d,  p);
      chk({tag, "_pc4"}, pc4_d, p + 32'd4);
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b1; stall = 1'b0;
    set_pc(32'h0);
    bus.gnt = 1'b1; bus.rvalid = 1'b0; bus.rdata = '0;

    // 1: reset held for three cycles; flush/gnt must not leak through
    repeat (3) tick();
    chk("rst_valid", 32'(valid_d), 32'd0);
    chk("rst_instr", instr_d,      NOP);
    chk("rst_pc",    pc_d,         32'h0);
    chk("rst_pc4",   pc4_d,        32'h0);
    chk("rst_req",   32'(bus.req), 32'd0);
    chk("rst_pcwr",  32'(pc_write), 32'd0);
    rst = 1'b0; flush = 1'b0; bus.gnt = 1'b0;

    // 2: straight-line fetch of 0, 4, 8
    req_grant(32'h0); respond(32'hA000_0000); chk_ifid("sl0", 1'b1, 32'h0, 32'hA000_0000);
    req_grant(32'h4); respond(32'hA000_0004); chk_ifid("sl4", 1'b1, 32'h4, 32'hA000_0004);
    req_grant(32'h8); respond(32'hA000_0008); chk_ifid("sl8", 1'b1, 32'h8, 32'hA000_0008);

    // 3: stall with 0x4 in IF/ID while 0x8 returns -> skid
    req_grant(32'h4); respond(32'hB000_0004); chk_ifid("st4", 1'b1, 32'h4, 32'hB000_0004);
    stall = 1'b1;
    req_grant(32'h8); respond(32'hB000_0008);
    set_pc(32'hC);
    #1;
    chk_ifid("skid_hold", 1'b1, 32'h4, 32'hB000_0004);
    chk("skid_blocks_req", 32'(bus.req), 32'd0);
    tick();
    chk_ifid("skid_hold2", 1'b1, 32'h4, 32'hB000_0004);
    chk("skid_blocks_req2", 32'(bus.req), 32'd0);
    stall = 1'b0;
    tick();
    chk_ifid("skid_out", 1'b1, 32'h8, 32'hB000_0008);
    chk("resume_req", 32'(bus.req), 32'd1);
    req_grant(32'hC); respond(32'hB000_000C); chk_ifid("stC", 1'b1, 32'hC, 32'hB000_000C);

    // 4: flush while 0x10 is outstanding (IF/ID held valid by stall)
    stall = 1'b1;
    req_grant(32'h10);
    chk_ifid("pre_flush", 1'b1, 32'hC, 32'hB000_000C);
    flush = 1'b1;
    #1;
    chk("flw_pcwr", 32'(pc_write), 32'd1);
    chk("flw_req",  32'(bus.req),  32'd0);
    tick();
    flush = 1'b0; stall = 1'b0;
    set_pc(32'h100);
    chk_ifid("flw_kill", 1'b0, 32'h0, NOP);
    chk("drain_req", 32'(bus.req), 32'd0);
    tick();
    bus.rvalid = 1'b1; bus.rdata = 32'hDEAD_0010;
    #1;
    chk("drain_req2", 32'(bus.req), 32'd0);
    tick();
    bus.rvalid = 1'b0;
    chk_ifid("flw_drop", 1'b0, 32'h0, NOP);
    chk("redirect_req",  32'(bus.req), 32'd1);
    chk("redirect_addr", bus.addr,     32'h100);
    req_grant(32'h100); respond(32'hC000_0100); chk_ifid("rd100", 1'b1, 32'h100, 32'hC000_0100);

    // 5: flush coincident with gnt in REQ -> DRAIN, next response discarded
    set_pc(32'h104);
    bus.gnt = 1'b1; flush = 1'b1;
    #1;
    chk("flg_pcwr", 32'(pc_write), 32'd1);
    chk("flg_req",  32'(bus.req),  32'd0);
    tick();
    bus.gnt = 1'b0; flush = 1'b0;
    set_pc(32'h200);
    chk_ifid("flg_kill", 1'b0, 32'h0, NOP);
    bus.rvalid = 1'b1; bus.rdata = 32'hBAD0_0104;
    #1;
    chk("flg_drain_req", 32'(bus.req), 32'd0);
    tick();
    bus.rvalid = 1'b0;
    chk_ifid("flg_drop", 1'b0, 32'h0, NOP);
    chk("flg_resume", 32'(bus.req), 32'd1);
    chk("flg_addr",   bus.addr,     32'h200);

    // 6: asynchronous reset pulsed between edges while 0x204 is in WAIT
    req_grant(32'h200); respond(32'hE000_0200); chk_ifid("ar200", 1'b1, 32'h200, 32'hE000_0200);
    stall = 1'b1;
    req_grant(32'h204);
    chk_ifid("ar_pre", 1'b1, 32'h200, 32'hE000_0200);
    #2 rst = 1'b1;
    #1;
    chk_ifid("ar_now", 1'b0, 32'h0, NOP);
    chk("ar_pc",   pc_d,          32'h0);
    chk("ar_req",  32'(bus.req),  32'd0);
    chk("ar_pcwr", 32'(pc_write), 32'd0);
    #1 rst = 1'b0;
    stall = 1'b0;
    bus.rvalid = 1'b1; bus.rdata = 32'hFACE_0204;
    tick();
    bus.rvalid = 1'b0;
    chk_ifid("ar_late", 1'b0, 32'h0, NOP);
    chk("ar_state_req", 32'(bus.req), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
